// File: rtl/ula_arbiter.sv
// Shares one ULA (via its Controller opcode decode) round-robin between NUM_REQ cores.
// Latency: gnt one edge after req is sampled, done ULA_LATENCY edges after gnt; one op per ULA_LATENCY+1 cycles.
// Backpressure: req/gnt handshake; cores hold req and operands until gnt; no new grant while an op is in flight.
//
// Ports:
//   clk, reset (async, active-low)
//   req / req_opcode / req_operand1 / req_operand2 : per-core request, 8-bit fields packed core i at [8i+7:8i]
//   gnt, done        : one-hot single-cycle pulses (operands latched / response valid)
//   rsp_result/flags : result and flags of the last completed op, held until the next done
//   ula_opcode/operand1/operand2 -> shared ULA, ula_result/ula_flags <- shared ULA
//   busy             : transaction in flight
// Optional feature, macro ULA_ARB_STATS_EN: adds op_count (saturating completed-op count)
// and last_owner (core index of the last completed op).
module ula_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ULA_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_opcode,
  input  logic [NUM_REQ*8-1:0]   req_operand1,
  input  logic [NUM_REQ*8-1:0]   req_operand2,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rsp_result,
  output logic [7:0]             rsp_flags,
  output logic [7:0]             ula_opcode,
  output logic [7:0]             ula_operand1,
  output logic [7:0]             ula_operand2,
  input  logic [7:0]             ula_result,
  input  logic [7:0]             ula_flags,
  output logic                   busy
`ifdef ULA_ARB_STATS_EN
  ,
  output logic [15:0]            op_count,
  output logic [$clog2(NUM_REQ)-1:0] last_owner
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ULA_LATENCY > 1) ? $clog2(ULA_LATENCY) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
  } op_t;

  state_t             state;
  logic [IDX_W-1:0]   last;     // previous winner; also the owner of the op in flight
  logic [CNT_W-1:0]   cnt;
  op_t                req_op [NUM_REQ];
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  op_t                win_op;
  logic               finish;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_op[i] = {req_opcode[8*i +: 8], req_operand1[8*i +: 8], req_operand2[8*i +: 8]};
  end

  // Scan distances NUM_REQ down to 1 from the pointer so that the last hit
  // written is the nearest requester after last, i.e. the round-robin winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[IDX_W'((int'(last) + i) % NUM_REQ)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  assign win_op = req_op[win_idx];
  assign finish = (state == EXEC) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last         <= IDX_W'(NUM_REQ - 1);
      cnt          <= '0;
      gnt          <= '0;
      done         <= '0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      ula_opcode   <= '0;
      ula_operand1 <= '0;
      ula_operand2 <= '0;
      busy         <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt          <= NUM_REQ'(1) << win_idx;
            ula_opcode   <= win_op.opcode;
            ula_operand1 <= win_op.operand1;
            ula_operand2 <= win_op.operand2;
            last         <= win_idx;
            busy         <= 1'b1;
            cnt          <= CNT_W'(ULA_LATENCY - 1);
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result <= ula_result;
            rsp_flags  <= ula_flags;
            done       <= NUM_REQ'(1) << last;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ULA_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count   <= '0;
      last_owner <= '0;
    end else if (finish) begin
      if (op_count != 16'hFFFF) begin
        op_count <= op_count + 1'b1;
      end
      last_owner <= last;
    end
  end
`endif

endmodule
